// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder : digit-serial add/subtract, DIGIT bits per clock, LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] Sum_o,
  output logic             Cout_o,
  output logic             Ovf_o
);

  localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1) begin : g_bad_digit
      $error("serial_adder: DIGIT must be at least 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
      $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic [DIGIT:0]     slice_d;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic               last_d;
  logic               ovf_d;

  assign slice_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
  assign last_d  = (cnt_q == CW'(N - 1));
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_d[DIGIT-1] ^ slice_d[DIGIT];

  // The operand-A register doubles as the result register: each slice sum
  // enters at the top while consumed bits leave at the bottom.
  generate
    if (DIGIT == WIDTH) begin : g_one_slice
      assign a_d = slice_d[DIGIT-1:0];
      assign b_d = '0;
    end else begin : g_multi_slice
      assign a_d = {slice_d[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
      assign b_d = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= slice_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= a_d;
            cout_q  <= slice_d[DIGIT];
            ovf_q   <= ovf_d;
          end
        end
        default: begin
          if (start_i) begin
            state_q <= S_RUN;
            a_q     <= A_i;
            b_q     <= sub_i ? ~B_i : B_i;
            carry_q <= sub_i ? ~Cin_i : Cin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign Sum_o  = sum_q;
  assign Cout_o = cout_q;
  assign Ovf_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder : directed checks on a 16/4 build plus 16/16 and 16/1 builds
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        v_start16, v_start1, v_sub, v_cin;
  logic [15:0] v_a, v_b;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .sub_i(sub), .A_i(a), .B_i(b),
    .Cin_i(cin), .busy_o(busy), .done_o(done), .Sum_o(sum), .Cout_o(cout), .Ovf_o(ovf)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start_i(v_start16), .sub_i(v_sub), .A_i(v_a), .B_i(v_b),
    .Cin_i(v_cin), .busy_o(busy16), .done_o(done16), .Sum_o(sum16), .Cout_o(cout16), .Ovf_o(ovf16)
  );

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start_i(v_start1), .sub_i(v_sub), .A_i(v_a), .B_i(v_b),
    .Cin_i(v_cin), .busy_o(busy1), .done_o(done1), .Sum_o(sum1), .Cout_o(cout1), .Ovf_o(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic reference: {ovf, cout, sum}
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
    logic [16:0] t;
    int sx, sy, r;
    sx = $signed(x);
    sy = $signed(y);
    if (!s) begin
      t = {1'b0, x} + {1'b0, y} + 17'(c);
      r = sx + sy + int'(c);
    end else begin
      t[15:0] = x - y - 16'(c);
      t[16]   = ({1'b0, x} >= ({1'b0, y} + 17'(c)));
      r = sx - sy - int'(c);
    end
    return {(r > 32767 || r < -32768), t[16], t[15:0]};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub,
                        input logic [15:0] es, input logic ec, input logic eo);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_run"}, {busy, done}, 2'b10);
      tick();
    end
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_res"}, {ovf, cout, sum}, {eo, ec, es});
    tick();
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int lat;
    logic [17:0] exp;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    v_start16 = 1'b0; v_start1 = 1'b0; v_sub = 1'b0; v_cin = 1'b0; v_a = '0; v_b = '0;
    tick();
    tick();
    chk("reset_flags", {busy, done, cout, ovf}, 4'b0000);
    chk("reset_sum", sum, 16'h0000);

    // First edge after release accepts start
    rst_n = 1'b1;
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",   16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_bin",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    tick();
    tick();
    chk("hold_res", {ovf, cout, sum}, {1'b0, 1'b1, 16'h000E});

    // Inputs and start are ignored in RUN; start in DONE chains without idle
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    a = 16'h0000; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("chain_run1", {busy, done}, 2'b10);
      tick();
    end
    chk("chain_done1", {busy, done}, 2'b01);
    chk("chain_res1", {ovf, cout, sum}, {1'b0, 1'b0, 16'h5555});
    tick();
    start = 1'b0;
    chk("chain_nogap", {busy, done}, 2'b10);
    chk("chain_keep", sum, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("chain_run2", {busy, done}, 2'b10);
    end
    tick();
    chk("chain_done2", {busy, done}, 2'b01);
    chk("chain_res2", {ovf, cout, sum}, {1'b0, 1'b0, 16'h4322});
    tick();

    // Asynchronous reset in the second RUN cycle abandons the operation
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", {busy, done, cout, ovf}, 4'b0000);
    chk("arst_sum", sum, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_nodone", {busy, done}, 2'b00);
    end
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // DIGIT=16 (latency 1) then DIGIT=1 (latency 16) against the reference
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        v_a = 16'($urandom);
        v_b = 16'($urandom);
        v_cin = 1'($urandom);
        v_sub = 1'($urandom);
        exp = ref_op(v_a, v_b, v_cin, v_sub);
        v_start16 = (m == 0);
        v_start1  = (m == 1);
        tick();
        v_start16 = 1'b0;
        v_start1  = 1'b0;
        lat = 0;
        while (!((m == 0) ? done16 : done1) && lat < 40) begin
          tick();
          lat++;
        end
        chk((m == 0) ? "d16_lat" : "d1_lat", lat, (m == 0) ? 1 : 16);
        chk((m == 0) ? "d16_res" : "d1_res",
            (m == 0) ? {ovf16, cout16, sum16} : {ovf1, cout1, sum1}, exp);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand and result width in bits.
REQ-002 The block SHALL take parameter DIGIT, default 4, as the number of bits added per clock cycle.
REQ-003 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 start  input  1  Request to begin an operation using the current A, B, Cin and sub.
REQ-006 sub  input  1  Mode: 0 selects A+B+Cin; 1 selects A-B-Cin.
REQ-007 A  input  WIDTH  Operand A.
REQ-008 B  input  WIDTH  Operand B.
REQ-009 Cin  input  1  Carry-in when sub=0; borrow-in when sub=1.
REQ-010 busy  output  1  High while an operation is in progress.
REQ-011 done  output  1  One-cycle pulse marking a new valid result.
REQ-012 Sum  output  WIDTH  Result, held until the next completion.
REQ-013 Cout  output  1  Raw carry out of the MSB; for sub=1, Cout=0 means a borrow occurred.
REQ-014 Ovf  output  1  Two's-complement signed overflow of the result.

Function
REQ-015 Elaboration SHALL fail unless WIDTH mod DIGIT = 0 and DIGIT >= 1; N = WIDTH/DIGIT.
REQ-016 The FSM SHALL have three states (IDLE, RUN, DONE), and start SHALL be accepted only in IDLE or DONE.
REQ-017 On an accepting edge, the block SHALL capture A, capture B' = sub ? ~B : B, set the carry register to sub ? ~Cin : Cin, clear the digit counter, and enter RUN.
REQ-018 In RUN, each edge SHALL add one DIGIT-bit slice (LSB slice first) of A, B' and the carry register, store the slice sum, update the carry, and increment the counter.
REQ-019 The edge that processes slice N-1 SHALL transition RUN to DONE and load Sum, Cout and Ovf.
REQ-020 Ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency from the accepting edge to done=1 SHALL be N cycles, with busy high for N cycles.
REQ-023 DONE SHALL return to IDLE on the next edge unless start=1, in which case it SHALL enter RUN with no idle gap.
REQ-024 While in RUN, start, A, B, Cin and sub SHALL be ignored; the result SHALL depend only on the captured values.
REQ-025 Sum, Cout and Ovf SHALL change only on the edge entering DONE (or on reset) and SHALL NOT be cleared by start.
REQ-026 With DIGIT=WIDTH (N=1), busy SHALL be high for one cycle and done SHALL be high on the following cycle.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-028 When rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, counter=0 and carry register=0.
REQ-029 Reset asserted during RUN SHALL abandon the operation with no done pulse.
REQ-030 The first edge with rst_n=1 SHALL be able to accept start.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 A=0x1234, B=0x4321, Cin=0, sub=0, start pulse -> busy high 4 cycles, then done pulse with Sum=0x5555, Cout=0, Ovf=0.
REQ-032 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; then A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-033 sub=1, A=0x0005, B=0x0007, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0; then sub=1, A=0x8000, B=0x0001, Cin=0 -> Sum=0x7FFF, Cout=1, Ovf=1.
REQ-034 start held high and A changed to 0x0000 during RUN -> result still 0x5555 from captured operands; start=1 in DONE -> busy rises next cycle with no IDLE cycle.
REQ-035 rst_n pulsed low during the 2nd RUN cycle -> all outputs 0 at once and no done pulse; a subsequent start of 0x0001+0x0001 -> Sum=0x0002 after 4 cycles.
REQ-036 DIGIT=16 and DIGIT=1 builds with random operands, both modes, 1000 ops each -> Sum, Cout and Ovf match a reference model, with latency 1 and 16 respectively.
